hbm_fc_tile_scheduler: RTL and testbench

//  Sequences the HBM FC+BN+RES layer over output-channel tiles (CHout/Tout). Per tile it

---
 rtl/hbm_fc_tile_scheduler_if.sv | 33 +++
 rtl/hbm_fc_tile_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_hbm_fc_tile_scheduler.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hbm_fc_tile_scheduler_if.sv
// hbm_fc_tile_scheduler_if: read/write DMA command channels plus the compute and
// write-completion pulses exchanged between the tile scheduler and the datapath.
interface hbm_fc_tile_scheduler_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 24,
    parameter int TILE_W = 12
);
    logic              rd_cmd_valid;
    logic              rd_cmd_ready;
    logic [1:0]        rd_cmd_type;
    logic [ADDR_W-1:0] rd_cmd_addr;
    logic [LEN_W-1:0]  rd_cmd_len;
    logic [TILE_W-1:0] rd_cmd_tile;
    logic              tile_compute_done;
    logic              wr_cmd_valid;
    logic              wr_cmd_ready;
    logic [ADDR_W-1:0] wr_cmd_addr;
    logic [LEN_W-1:0]  wr_cmd_len;
    logic [TILE_W-1:0] wr_cmd_tile;
    logic              wr_done;

    modport master (
        output rd_cmd_valid, rd_cmd_type, rd_cmd_addr, rd_cmd_len, rd_cmd_tile,
        output wr_cmd_valid, wr_cmd_addr, wr_cmd_len, wr_cmd_tile,
        input  rd_cmd_ready, wr_cmd_ready, tile_compute_done, wr_done
    );

    modport slave (
        input  rd_cmd_valid, rd_cmd_type, rd_cmd_addr, rd_cmd_len, rd_cmd_tile,
        input  wr_cmd_valid, wr_cmd_addr, wr_cmd_len, wr_cmd_tile,
        output rd_cmd_ready, wr_cmd_ready, tile_compute_done, wr_done
    );
endinterface

// File: rtl/hbm_fc_tile_scheduler.sv
// hbm_fc_tile_scheduler: walks output-channel tiles, issuing WT/BN/RES reads and output
// writes, with up to MAX_INFLIGHT tiles overlapping between read issue and write-back.
module hbm_fc_tile_scheduler #(
    parameter int ADDR_W       = 32,
    parameter int LEN_W        = 24,
    parameter int TILE_W       = 12,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [TILE_W-1:0]      cfg_tiles,
    input  logic                   cfg_res_en,
    input  logic [ADDR_W-1:0]      cfg_wt_base,
    input  logic [LEN_W-1:0]       cfg_wt_tile_bytes,
    input  logic [ADDR_W-1:0]      cfg_bn_base,
    input  logic [LEN_W-1:0]       cfg_bn_tile_bytes,
    input  logic [ADDR_W-1:0]      cfg_res_base,
    input  logic [LEN_W-1:0]       cfg_res_stride,
    input  logic [ADDR_W-1:0]      cfg_out_base,
    input  logic [LEN_W-1:0]       cfg_out_stride,
    hbm_fc_tile_scheduler_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam int IW = 3;

    typedef enum logic [2:0] {RD_IDLE, RD_GATE, RD_WT, RD_BN, RD_RES} rd_st_t;
    typedef enum logic {WR_IDLE, WR_REQ} wr_st_t;

    rd_st_t            rd_st_q, rd_st_d;
    wr_st_t            wr_st_q, wr_st_d;
    logic [TILE_W-1:0] tiles_q, tiles_d;
    logic              res_en_q, res_en_d;
    logic [LEN_W-1:0]  wt_bytes_q, wt_bytes_d, bn_bytes_q, bn_bytes_d;
    logic [LEN_W-1:0]  res_stride_q, res_stride_d, out_stride_q, out_stride_d;
    logic [ADDR_W-1:0] wt_ptr_q, wt_ptr_d, bn_ptr_q, bn_ptr_d;
    logic [ADDR_W-1:0] res_ptr_q, res_ptr_d, out_ptr_q, out_ptr_d;
    logic [TILE_W-1:0] rd_tile_q, rd_tile_d, wr_tile_q, wr_tile_d;
    logic [TILE_W-1:0] issued_q, issued_d, comp_q, comp_d;
    logic [TILE_W-1:0] wr_cnt_q, wr_cnt_d, wd_cnt_q, wd_cnt_d;
    logic [IW-1:0]     inflight_q, inflight_d, pend_q, pend_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              rd_valid_q, rd_valid_d;
    logic [1:0]        rd_type_q, rd_type_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]  rd_len_q, rd_len_d;

    logic   rd_hs, wt_hs, bn_hs, res_hs, wr_hs, cd_ok, wd_ok, gate_ok, rd_last, tile_end;
    rd_st_t nxt_st;

    always_comb begin
        rd_st_d      = rd_st_q;
        wr_st_d      = wr_st_q;
        tiles_d      = tiles_q;
        res_en_d     = res_en_q;
        wt_bytes_d   = wt_bytes_q;
        bn_bytes_d   = bn_bytes_q;
        res_stride_d = res_stride_q;
        out_stride_d = out_stride_q;
        wt_ptr_d     = wt_ptr_q;
        bn_ptr_d     = bn_ptr_q;
        res_ptr_d    = res_ptr_q;
        out_ptr_d    = out_ptr_q;
        rd_tile_d    = rd_tile_q;
        wr_tile_d    = wr_tile_q;
        issued_d     = issued_q;
        comp_d       = comp_q;
        wr_cnt_d     = wr_cnt_q;
        wd_cnt_d     = wd_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        rd_hs        = busy_q && rd_valid_q && bus.rd_cmd_ready;
        wt_hs        = rd_hs && rd_st_q == RD_WT;
        bn_hs        = rd_hs && rd_st_q == RD_BN;
        res_hs       = rd_hs && rd_st_q == RD_RES;
        wr_hs        = busy_q && wr_st_q == WR_REQ && bus.wr_cmd_ready;
        cd_ok        = busy_q && bus.tile_compute_done && comp_q != issued_q;
        wd_ok        = busy_q && bus.wr_done && wd_cnt_q != wr_cnt_q;
        err_d        = err_q | (busy_q && bus.tile_compute_done && comp_q == issued_q)
                             | (busy_q && bus.wr_done && wd_cnt_q == wr_cnt_q);
        inflight_d   = inflight_q + IW'(wt_hs) - IW'(wd_ok);
        pend_d       = pend_q + IW'(cd_ok) - IW'(wr_hs);
        gate_ok      = inflight_d < IW'(MAX_INFLIGHT);
        rd_last      = rd_tile_q == tiles_q - TILE_W'(1);
        tile_end     = res_hs || (bn_hs && !res_en_q);
        nxt_st       = rd_last ? RD_IDLE : gate_ok ? RD_WT : RD_GATE;
        if (start && !busy_q) begin
            tiles_d      = cfg_tiles;
            res_en_d     = cfg_res_en;
            wt_bytes_d   = cfg_wt_tile_bytes;
            bn_bytes_d   = cfg_bn_tile_bytes;
            res_stride_d = cfg_res_stride;
            out_stride_d = cfg_out_stride;
            wt_ptr_d     = cfg_wt_base;
            bn_ptr_d     = cfg_bn_base;
            res_ptr_d    = cfg_res_base;
            out_ptr_d    = cfg_out_base;
            rd_tile_d    = '0;
            wr_tile_d    = '0;
            issued_d     = '0;
            comp_d       = '0;
            wr_cnt_d     = '0;
            wd_cnt_d     = '0;
            inflight_d   = '0;
            pend_d       = '0;
            busy_d       = 1'b1;
            err_d        = 1'b0;
            wr_st_d      = WR_IDLE;
            rd_st_d      = cfg_tiles != '0 ? RD_WT : RD_IDLE;
        end else if (busy_q) begin
            issued_d  = issued_q + TILE_W'(wt_hs);
            comp_d    = comp_q + TILE_W'(cd_ok);
            wr_cnt_d  = wr_cnt_q + TILE_W'(wr_hs);
            wd_cnt_d  = wd_cnt_q + TILE_W'(wd_ok);
            wt_ptr_d  = wt_hs ? wt_ptr_q + ADDR_W'(wt_bytes_q) : wt_ptr_q;
            bn_ptr_d  = bn_hs ? bn_ptr_q + ADDR_W'(bn_bytes_q) : bn_ptr_q;
            res_ptr_d = res_hs ? res_ptr_q + ADDR_W'(res_stride_q) : res_ptr_q;
            out_ptr_d = wr_hs ? out_ptr_q + ADDR_W'(out_stride_q) : out_ptr_q;
            wr_tile_d = wr_tile_q + TILE_W'(wr_hs);
            rd_tile_d = tile_end && !rd_last ? rd_tile_q + TILE_W'(1) : rd_tile_q;
            wr_st_d   = pend_d != '0 ? WR_REQ : WR_IDLE;
            case (rd_st_q)
                RD_GATE: rd_st_d = gate_ok ? RD_WT : RD_GATE;
                RD_WT:   rd_st_d = wt_hs ? RD_BN : RD_WT;
                RD_BN:   rd_st_d = bn_hs ? (res_en_q ? RD_RES : nxt_st) : RD_BN;
                RD_RES:  rd_st_d = res_hs ? nxt_st : RD_RES;
                default: rd_st_d = rd_st_q;
            endcase
            // every tile written back: wind the layer down
            if (wd_cnt_q == tiles_q) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                rd_st_d = RD_IDLE;
                wr_st_d = WR_IDLE;
            end
        end
        rd_valid_d = rd_st_d == RD_WT || rd_st_d == RD_BN || rd_st_d == RD_RES;
        rd_type_d  = rd_st_d == RD_BN ? 2'd1 : rd_st_d == RD_RES ? 2'd2 : 2'd0;
        rd_addr_d  = rd_st_d == RD_BN ? bn_ptr_d : rd_st_d == RD_RES ? res_ptr_d : wt_ptr_d;
        rd_len_d   = rd_st_d == RD_BN ? bn_bytes_d : rd_st_d == RD_RES ? res_stride_d : wt_bytes_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_st_q      <= RD_IDLE;
            wr_st_q      <= WR_IDLE;
            tiles_q      <= '0;
            res_en_q     <= 1'b0;
            wt_bytes_q   <= '0;
            bn_bytes_q   <= '0;
            res_stride_q <= '0;
            out_stride_q <= '0;
            wt_ptr_q     <= '0;
            bn_ptr_q     <= '0;
            res_ptr_q    <= '0;
            out_ptr_q    <= '0;
            rd_tile_q    <= '0;
            wr_tile_q    <= '0;
            issued_q     <= '0;
            comp_q       <= '0;
            wr_cnt_q     <= '0;
            wd_cnt_q     <= '0;
            inflight_q   <= '0;
            pend_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_type_q    <= '0;
            rd_addr_q    <= '0;
            rd_len_q     <= '0;
        end else begin
            rd_st_q      <= rd_st_d;
            wr_st_q      <= wr_st_d;
            tiles_q      <= tiles_d;
            res_en_q     <= res_en_d;
            wt_bytes_q   <= wt_bytes_d;
            bn_bytes_q   <= bn_bytes_d;
            res_stride_q <= res_stride_d;
            out_stride_q <= out_stride_d;
            wt_ptr_q     <= wt_ptr_d;
            bn_ptr_q     <= bn_ptr_d;
            res_ptr_q    <= res_ptr_d;
            out_ptr_q    <= out_ptr_d;
            rd_tile_q    <= rd_tile_d;
            wr_tile_q    <= wr_tile_d;
            issued_q     <= issued_d;
            comp_q       <= comp_d;
            wr_cnt_q     <= wr_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
            inflight_q   <= inflight_d;
            pend_q       <= pend_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rd_valid_q   <= rd_valid_d;
            rd_type_q    <= rd_type_d;
            rd_addr_q    <= rd_addr_d;
            rd_len_q     <= rd_len_d;
        end
    end

    assign bus.rd_cmd_valid = rd_valid_q;
    assign bus.rd_cmd_type  = rd_type_q;
    assign bus.rd_cmd_addr  = rd_addr_q;
    assign bus.rd_cmd_len   = rd_len_q;
    assign bus.rd_cmd_tile  = rd_tile_q;
    assign bus.wr_cmd_valid = wr_st_q == WR_REQ;
    assign bus.wr_cmd_addr  = out_ptr_q;
    assign bus.wr_cmd_len   = out_stride_q;
    assign bus.wr_cmd_tile  = wr_tile_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;
endmodule

// File: tb/tb_hbm_fc_tile_scheduler.sv
// tb_hbm_fc_tile_scheduler: directed scenarios for the tile scheduler, each task checking
// read/write command tuples and status flags against hand-computed values.
module tb_hbm_fc_tile_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] cfg_tiles = '0;
    logic        cfg_res_en = 1'b0;
    logic [31:0] cfg_wt_base = '0, cfg_bn_base = '0, cfg_res_base = '0, cfg_out_base = '0;
    logic [23:0] cfg_wt_tile_bytes = '0, cfg_bn_tile_bytes = '0;
    logic [23:0] cfg_res_stride = '0, cfg_out_stride = '0;
    logic        busy, done, err;
    int          total = 0;
    int          bad = 0;

    hbm_fc_tile_scheduler_if #(.ADDR_W(32), .LEN_W(24), .TILE_W(12)) bus ();

    hbm_fc_tile_scheduler #(.ADDR_W(32), .LEN_W(24), .TILE_W(12), .MAX_INFLIGHT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_tiles(cfg_tiles), .cfg_res_en(cfg_res_en),
        .cfg_wt_base(cfg_wt_base), .cfg_wt_tile_bytes(cfg_wt_tile_bytes),
        .cfg_bn_base(cfg_bn_base), .cfg_bn_tile_bytes(cfg_bn_tile_bytes),
        .cfg_res_base(cfg_res_base), .cfg_res_stride(cfg_res_stride),
        .cfg_out_base(cfg_out_base), .cfg_out_stride(cfg_out_stride),
        .bus(bus), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    wire [70:0] rd_obs = {bus.rd_cmd_valid, bus.rd_cmd_type, bus.rd_cmd_addr, bus.rd_cmd_len, bus.rd_cmd_tile};
    wire [68:0] wr_obs = {bus.wr_cmd_valid, bus.wr_cmd_addr, bus.wr_cmd_len, bus.wr_cmd_tile};

    function automatic logic [70:0] rdx(input logic [1:0] t, input logic [31:0] a,
                                        input logic [23:0] l, input logic [11:0] tl);
        return {1'b1, t, a, l, tl};
    endfunction

    function automatic logic [68:0] wrx(input logic [31:0] a, input logic [23:0] l, input logic [11:0] tl);
        return {1'b1, a, l, tl};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic kick;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_cd;
        bus.tile_compute_done = 1'b1;
        tick();
        bus.tile_compute_done = 1'b0;
    endtask

    task automatic pulse_wd;
        bus.wr_done = 1'b1;
        tick();
        bus.wr_done = 1'b0;
    endtask

    task automatic test_reset;
        tick();
        tick();
        total++;
        if ({rd_obs, wr_obs, busy, done, err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got rd=%h wr=%h busy=%b done=%b err=%b exp all zero", rd_obs, wr_obs, busy, done, err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pipeline;
        logic [70:0] e [6];
        cfg_tiles = 12'd3; cfg_res_en = 1'b1;
        cfg_wt_base = 32'h0; cfg_wt_tile_bytes = 24'h1100;
        cfg_bn_base = 32'h10000; cfg_bn_tile_bytes = 24'h200;
        cfg_res_base = 32'h20000; cfg_res_stride = 24'h400;
        cfg_out_base = 32'h30000; cfg_out_stride = 24'h800;
        bus.rd_cmd_ready = 1'b1; bus.wr_cmd_ready = 1'b1;
        e = '{rdx(2'd0, 32'h0, 24'h1100, 12'd0), rdx(2'd1, 32'h10000, 24'h200, 12'd0),
              rdx(2'd2, 32'h20000, 24'h400, 12'd0), rdx(2'd0, 32'h1100, 24'h1100, 12'd1),
              rdx(2'd1, 32'h10200, 24'h200, 12'd1), rdx(2'd2, 32'h20400, 24'h400, 12'd1)};
        kick();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy got=%b exp=1", busy); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (rd_obs !== e[i]) begin bad++; $display("FAIL t1_rd[%0d] got=%h exp=%h", i, rd_obs, e[i]); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.rd_cmd_valid !== 1'b0) begin bad++; $display("FAIL t1_gate[%0d] rd_valid got=%b exp=0", i, bus.rd_cmd_valid); end
            tick();
        end
        pulse_cd();
        total++;
        if (wr_obs !== wrx(32'h30000, 24'h800, 12'd0)) begin bad++; $display("FAIL t1_wr0 got=%h exp=%h", wr_obs, wrx(32'h30000, 24'h800, 12'd0)); end
        tick();
        total++;
        if ({bus.wr_cmd_valid, bus.rd_cmd_valid} !== 2'b00) begin bad++; $display("FAIL t1_after_wr0 wr/rd valid got=%b exp=00", {bus.wr_cmd_valid, bus.rd_cmd_valid}); end
        pulse_wd();
        total++;
        if (rd_obs !== rdx(2'd0, 32'h2200, 24'h1100, 12'd2)) begin bad++; $display("FAIL t1_wt2 got=%h exp=%h", rd_obs, rdx(2'd0, 32'h2200, 24'h1100, 12'd2)); end
        tick();
        total++;
        if (rd_obs !== rdx(2'd1, 32'h10400, 24'h200, 12'd2)) begin bad++; $display("FAIL t1_bn2 got=%h exp=%h", rd_obs, rdx(2'd1, 32'h10400, 24'h200, 12'd2)); end
        tick();
        total++;
        if (rd_obs !== rdx(2'd2, 32'h20800, 24'h400, 12'd2)) begin bad++; $display("FAIL t1_res2 got=%h exp=%h", rd_obs, rdx(2'd2, 32'h20800, 24'h400, 12'd2)); end
        tick();
        total++;
        if (bus.rd_cmd_valid !== 1'b0) begin bad++; $display("FAIL t1_rd_idle got=%b exp=0", bus.rd_cmd_valid); end
        pulse_cd();
        total++;
        if (wr_obs !== wrx(32'h30800, 24'h800, 12'd1)) begin bad++; $display("FAIL t1_wr1 got=%h exp=%h", wr_obs, wrx(32'h30800, 24'h800, 12'd1)); end
        tick();
        pulse_cd();
        total++;
        if (wr_obs !== wrx(32'h31000, 24'h800, 12'd2)) begin bad++; $display("FAIL t1_wr2 got=%h exp=%h", wr_obs, wrx(32'h31000, 24'h800, 12'd2)); end
        tick();
        pulse_wd();
        pulse_wd();
        total++;
        if ({busy, done} !== 2'b10) begin bad++; $display("FAIL t1_pre_done busy/done got=%b exp=10", {busy, done}); end
        tick();
        total++;
        if ({busy, done, err} !== 3'b010) begin bad++; $display("FAIL t1_done busy/done/err got=%b exp=010", {busy, done, err}); end
        tick();
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL t1_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_no_res;
        logic [70:0] e [4];
        int dn = 0;
        cfg_tiles = 12'd2; cfg_res_en = 1'b0;
        cfg_wt_base = 32'h4000; cfg_wt_tile_bytes = 24'h100;
        cfg_bn_base = 32'h5000; cfg_bn_tile_bytes = 24'h40;
        cfg_res_base = 32'h7000; cfg_res_stride = 24'h999;
        cfg_out_base = 32'h8000; cfg_out_stride = 24'h300;
        e = '{rdx(2'd0, 32'h4000, 24'h100, 12'd0), rdx(2'd1, 32'h5000, 24'h40, 12'd0),
              rdx(2'd0, 32'h4100, 24'h100, 12'd1), rdx(2'd1, 32'h5040, 24'h40, 12'd1)};
        kick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_obs !== e[i]) begin bad++; $display("FAIL t2_rd[%0d] got=%h exp=%h", i, rd_obs, e[i]); end
            tick();
        end
        total++;
        if (bus.rd_cmd_valid !== 1'b0) begin bad++; $display("FAIL t2_rd_idle got=%b exp=0", bus.rd_cmd_valid); end
        pulse_cd();
        total++;
        if (wr_obs !== wrx(32'h8000, 24'h300, 12'd0)) begin bad++; $display("FAIL t2_wr0 got=%h exp=%h", wr_obs, wrx(32'h8000, 24'h300, 12'd0)); end
        tick();
        pulse_cd();
        total++;
        if (wr_obs !== wrx(32'h8300, 24'h300, 12'd1)) begin bad++; $display("FAIL t2_wr1 got=%h exp=%h", wr_obs, wrx(32'h8300, 24'h300, 12'd1)); end
        tick();
        pulse_wd();
        pulse_wd();
        for (int i = 0; i < 4; i++) begin
            dn += int'(done);
            tick();
        end
        total++;
        if (dn != 1 || busy !== 1'b0) begin bad++; $display("FAIL t2_done_count got=%0d busy=%b exp=1 busy=0", dn, busy); end
    endtask

    task automatic test_stall;
        cfg_tiles = 12'd1; cfg_res_en = 1'b0;
        cfg_wt_base = 32'h100; cfg_wt_tile_bytes = 24'h80;
        cfg_bn_base = 32'h900; cfg_bn_tile_bytes = 24'h20;
        cfg_out_base = 32'hA000; cfg_out_stride = 24'h10;
        bus.rd_cmd_ready = 1'b0;
        kick();
        bus.rd_cmd_ready = 1'b1;
        tick();
        bus.rd_cmd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (rd_obs !== rdx(2'd1, 32'h900, 24'h20, 12'd0)) begin bad++; $display("FAIL t3_hold[%0d] got=%h exp=%h", i, rd_obs, rdx(2'd1, 32'h900, 24'h20, 12'd0)); end
            if (i < 5) tick();
        end
        bus.rd_cmd_ready = 1'b1;
        tick();
        total++;
        if (bus.rd_cmd_valid !== 1'b0) begin bad++; $display("FAIL t3_rd_idle got=%b exp=0", bus.rd_cmd_valid); end
        pulse_cd();
        tick();
        pulse_wd();
        tick();
        total++;
        if ({busy, done} !== 2'b01) begin bad++; $display("FAIL t3_done busy/done got=%b exp=01", {busy, done}); end
        tick();
    endtask

    task automatic test_zero;
        cfg_tiles = 12'd0;
        kick();
        total++;
        if ({busy, done, bus.rd_cmd_valid, bus.wr_cmd_valid} !== 4'b1000) begin bad++; $display("FAIL t4_c1 busy/done/rv/wv got=%b exp=1000", {busy, done, bus.rd_cmd_valid, bus.wr_cmd_valid}); end
        tick();
        total++;
        if ({busy, done, bus.rd_cmd_valid, bus.wr_cmd_valid} !== 4'b0100) begin bad++; $display("FAIL t4_c2 busy/done/rv/wv got=%b exp=0100", {busy, done, bus.rd_cmd_valid, bus.wr_cmd_valid}); end
        tick();
        total++;
        if ({busy, done} !== 2'b00) begin bad++; $display("FAIL t4_c3 busy/done got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_err;
        cfg_tiles = 12'd1; cfg_res_en = 1'b0;
        bus.rd_cmd_ready = 1'b0;
        kick();
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL t5_err_init got=%b exp=0", err); end
        pulse_cd();
        total++;
        if ({err, bus.wr_cmd_valid} !== 2'b10) begin bad++; $display("FAIL t5_early_cd err/wv got=%b exp=10", {err, bus.wr_cmd_valid}); end
        bus.rd_cmd_ready = 1'b1;
        tick();
        tick();
        pulse_cd();
        total++;
        if (bus.wr_cmd_valid !== 1'b1) begin bad++; $display("FAIL t5_real_cd wv got=%b exp=1", bus.wr_cmd_valid); end
        tick();
        pulse_wd();
        tick();
        total++;
        if ({done, err} !== 2'b11) begin bad++; $display("FAIL t5_sticky done/err got=%b exp=11", {done, err}); end
        cfg_tiles = 12'd0;
        kick();
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL t5_clear got=%b exp=0", err); end
        tick();
        tick();
    endtask

    task automatic test_async_reset;
        cfg_tiles = 12'd2; cfg_res_en = 1'b1;
        cfg_wt_base = 32'h100; cfg_wt_tile_bytes = 24'h40;
        bus.rd_cmd_ready = 1'b1;
        kick();
        tick();
        tick();
        tick();
        bus.rd_cmd_ready = 1'b0;
        total++;
        if (rd_obs !== rdx(2'd0, 32'h140, 24'h40, 12'd1)) begin bad++; $display("FAIL t6_wt1 got=%h exp=%h", rd_obs, rdx(2'd0, 32'h140, 24'h40, 12'd1)); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({rd_obs, wr_obs, busy, done, err} !== '0) begin bad++; $display("FAIL t6_async rd=%h wr=%h busy=%b done=%b err=%b exp all zero", rd_obs, wr_obs, busy, done, err); end
        #2 rst_n = 1'b1;
        tick();
        cfg_tiles = 12'd1; cfg_res_en = 1'b0;
        kick();
        total++;
        if ({busy, rd_obs} !== {1'b1, rdx(2'd0, 32'h100, 24'h40, 12'd0)}) begin bad++; $display("FAIL t6_restart busy=%b rd=%h exp busy=1 rd=%h", busy, rd_obs, rdx(2'd0, 32'h100, 24'h40, 12'd0)); end
    endtask

    initial begin
        bus.rd_cmd_ready = 1'b0;
        bus.wr_cmd_ready = 1'b1;
        bus.tile_compute_done = 1'b0;
        bus.wr_done = 1'b0;
        test_reset();
        test_pipeline();
        test_no_res();
        test_stall();
        test_zero();
        test_err();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
